// File: rtl/vision_pkg.sv
// vision_pkg: pixel/window types, default image size and window index constants
package vision_pkg;
  typedef logic [15:0] pixel_t;
  typedef pixel_t [8:0] window3x3_t;
  localparam int IMG_WIDTH_DEF = 320;
  localparam int IMG_HEIGHT_DEF = 240;
  localparam int WIN_TL = 8;
  localparam int WIN_C = 4;
  localparam int WIN_BR = 0;
  typedef enum logic [1:0] {WAIT_SOF, FILL, STREAM} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: DEPTH x PIX_W RAM, one write port and one synchronous read-old-data port
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int PIX_W = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [PIX_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [PIX_W-1:0]         rd_data
);
  logic [PIX_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/window_gen_3x3_rgb565.sv
// window_gen_3x3_rgb565: streaming 3x3 window generator over two line buffers.
// Define WINDOW_GEN_STATS_EN to enable the per-frame win_count statistic.
module window_gen_3x3_rgb565
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = 16,
  localparam int XW   = $clog2(IMG_WIDTH),
  localparam int YW   = $clog2(IMG_HEIGHT),
  localparam int CNTW = $clog2(IMG_WIDTH*IMG_HEIGHT)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic [PIX_W-1:0] win_out [8:0],
  output logic             win_valid,
  output logic [XW-1:0]    center_x,
  output logic [YW-1:0]    center_y,
  output logic             frame_done,
  output logic [CNTW-1:0]  win_count
);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH-1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT-1);
  state_t state, state_nx;
  logic [XW-1:0] col, cur_x, nx_x, rd_addr;
  logic [YW-1:0] row, cur_y, nx_y;
  logic sof, acc, eol, last, emit;
  logic [PIX_W-1:0] top, mid;
  logic [PIX_W-1:0] s0 [2:0];
  logic [PIX_W-1:0] s1 [2:0];
  always_comb begin
    sof = pix_valid && pix_sof;
    acc = pix_valid && (sof || state != WAIT_SOF);
    cur_x = sof ? '0 : col;
    cur_y = sof ? '0 : row;
    eol = cur_x == X_MAX;
    last = eol && cur_y == Y_MAX;
    emit = acc && state == STREAM && cur_x >= XW'(2);
    nx_x = eol ? '0 : cur_x + 1'b1;
    nx_y = last ? '0 : eol ? cur_y + 1'b1 : cur_y;
    // read ahead at the column the next accepted pixel will land on
    rd_addr = acc ? nx_x : col;
    state_nx = !acc ? state :
               last ? WAIT_SOF :
               sof ? FILL :
               (eol && cur_y == YW'(1)) ? STREAM : state;
  end
  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk(clk), .we(acc), .wr_addr(cur_x), .wr_data(pix_in), .rd_addr(rd_addr), .rd_data(mid)
  );
  line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk(clk), .we(acc), .wr_addr(cur_x), .wr_data(mid), .rd_addr(rd_addr), .rd_data(top)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_SOF;
      col <= '0;
      row <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
      center_x <= '0;
      center_y <= '0;
      win_out <= '{default: '0};
    end else begin
      state <= state_nx;
      win_valid <= emit;
      frame_done <= emit && last;
      if (acc) begin
        col <= nx_x;
        row <= nx_y;
        s1 <= s0;
        s0 <= '{top, mid, pix_in};
      end
      if (emit) begin
        win_out <= '{s1[2], s0[2], top, s1[1], s0[1], mid, s1[0], s0[0], pix_in};
        center_x <= cur_x - 1'b1;
        center_y <= cur_y - 1'b1;
      end
    end
  end
`ifdef WINDOW_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || sof) win_count <= '0;
    else if (emit) win_count <= win_count + 1'b1;
  end
`else
  assign win_count = '0;
`endif
endmodule

// File: tb/tb_window_gen_3x3_rgb565.sv
// tb_window_gen_3x3_rgb565: directed frames checked against a coordinate/image model of the window generator
module tb_window_gen_3x3_rgb565;
  localparam int W = 8, H = 6;
  logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0;
  logic [15:0] pix_in = '0;
  logic [15:0] win_out [8:0];
  logic win_valid, frame_done;
  logic [2:0] center_x, center_y;
  logic [6:0] win_count;
  int n_vec = 0, n_err = 0, gap_pct = 0, nwin = 0;
  logic [15:0] img [H][W];
  logic [15:0] e_win [9];
  bit in_frame, e_valid, e_done;
  int mr, mc, e_cnt, e_cx, e_cy;

  always #5 clk = ~clk;

  window_gen_3x3_rgb565 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .win_out(win_out), .win_valid(win_valid), .center_x(center_x), .center_y(center_y),
    .frame_done(frame_done), .win_count(win_count)
  );

  function automatic logic [15:0] pv(int tag, int r, int c);
    return 16'((tag << 8) | (r << 4) | c);
  endfunction

  task automatic cmp(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // expectation for the cycle after this input: the window around the pixel just placed in the image
  task automatic model(bit rst, bit v, bit s, logic [15:0] p);
    e_valid = 0;
    e_done = 0;
    if (rst) begin
      in_frame = 0; mr = 0; mc = 0; e_cnt = 0; e_cx = 0; e_cy = 0;
      for (int k = 0; k < 9; k++) e_win[k] = '0;
    end else if (v && (s || in_frame)) begin
      if (s) begin in_frame = 1; mr = 0; mc = 0; e_cnt = 0; end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        e_valid = 1; e_cnt++; e_cx = mc - 1; e_cy = mr - 1;
        for (int k = 0; k < 9; k++) e_win[8-k] = img[mr-2+k/3][mc-2+k%3];
      end
      if (mr == H-1 && mc == W-1) begin e_done = 1; in_frame = 0; end
      if (mc == W-1) begin mc = 0; mr = (mr + 1) % H; end
      else mc++;
    end
  endtask

  task automatic check();
    cmp("win_valid", win_valid, e_valid);
    cmp("frame_done", frame_done, e_done);
    for (int k = 0; k < 9; k++) cmp($sformatf("win_out[%0d]", k), win_out[k], e_win[k]);
    if (e_valid) begin
      cmp("center_x", center_x, e_cx);
      cmp("center_y", center_y, e_cy);
    end
`ifdef WINDOW_GEN_STATS_EN
    cmp("win_count", win_count, e_cnt);
`else
    cmp("win_count", win_count, 0);
`endif
    if (win_valid) nwin++;
  endtask

  task automatic step(bit rst, bit v, bit s, logic [15:0] p);
    rst_n = !rst; pix_valid = v; pix_sof = s; pix_in = p;
    model(rst, v, s, p);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask

  task automatic send(int r, int c, int tag, bit s);
    for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) step(0, 0, 0, 16'hDEAD);
    step(0, 1, s, pv(tag, r, c));
    if (s) cmp("sof_count_clr", win_count, 0);
    if (r == 2 && c == 2) begin
      cmp("first_valid", win_valid, 1);
      cmp("first_tl", win_out[8], (tag << 8) | 16'h0000);
      cmp("first_c", win_out[4], (tag << 8) | 16'h0011);
      cmp("first_br", win_out[0], (tag << 8) | 16'h0022);
      cmp("first_cx", center_x, 1);
      cmp("first_cy", center_y, 1);
    end
    if (r == 3 && c < 2) cmp("wrap_none", win_valid, 0);
    if (r == 3 && c == 2) begin
      cmp("wrap_tl", win_out[8], (tag << 8) | 16'h0010);
      cmp("wrap_br", win_out[0], (tag << 8) | 16'h0032);
    end
    if (r == H-1 && c == W-1) begin
      cmp("last_br", win_out[0], (tag << 8) | 16'h0057);
      cmp("last_done", frame_done, 1);
`ifdef WINDOW_GEN_STATS_EN
      cmp("count_done", win_count, 24);
`endif
    end
  endtask

  task automatic frame(int tag, int stop);
    for (int i = 0; i < stop; i++) send(i / W, i % W, tag, i == 0);
  endtask

  initial begin
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    cmp("rst_valid", win_valid, 0);
    cmp("rst_cx", center_x, 0);
    cmp("rst_cy", center_y, 0);
    cmp("rst_count", win_count, 0);
    repeat (3) step(0, 1, 0, 16'h1234);
    cmp("pre_sof_none", nwin, 0);
    nwin = 0; frame(0, W*H);
    cmp("total_cont", nwin, 24);
    repeat (5) step(0, 0, 0, '0);
    gap_pct = 40; nwin = 0; frame(0, W*H);
    cmp("total_gaps", nwin, 24);
    gap_pct = 0;
    frame(0, 3*W + 4);
    nwin = 0; frame(8'h5A, W*H);
    cmp("total_resof", nwin, 24);
    frame(0, 4*W + 5);
    step(1, 1, 0, pv(0, 4, 5));
    cmp("midrst_valid", win_valid, 0);
    cmp("midrst_br", win_out[0], 0);
    cmp("midrst_cx", center_x, 0);
    cmp("midrst_cy", center_y, 0);
    nwin = 0;
    repeat (2) step(0, 1, 0, pv(0, 4, 6));
    cmp("wait_sof_none", nwin, 0);
    frame(0, W*H);
    cmp("total_after_rst", nwin, 24);
    repeat (3) step(0, 0, 0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
